rtc_ad_sequencer: RTL

RTC_AD_SEQUENCER -- requirements
Module: rtc_ad_sequencer

---
 rtl/rtc_ad_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_ad_sequencer.sv
// ---------------------------------------------------------------------------
// rtc_ad_sequencer
//
// Drives a multiplexed address/data bus of a parallel RTC chip. One bus
// transaction is an address phase followed by a data phase:
//   A_SETUP -> A_STROBE -> A_HOLD -> D_SETUP -> D_STROBE -> D_HOLD -> DONE
// SETUP/HOLD states last GAP_CYC cycles and STROBE states last PHASE_CYC
// cycles. The timing comes from a single 4-bit down-counter.
//
// Parameters
//   GAP_CYC    setup/hold cycles around each strobe (1..15)
//   PHASE_CYC  strobe width in cycles (1..15)
//
// Optional feature
//   RTC_CMD_QUEUE_EN  when defined, a start that arrives while busy is held
//                     in a one-entry pending slot. The held command is
//                     launched from DONE straight into A_SETUP.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   start, rd_wr           transaction request; 1 = read, 0 = write
//   addr, wdata            register address and write data
//   ad_in                  bus data returned by the RTC
//   addr_q, wdata_q        latched address/data feeding the external a/d mux
//   mux_sel                1 = addr_q on the bus, 0 = wdata_q
//   ad_oe                  bus output enable
//   cs_n, ad_n, rd_n, wr_n active-low chip select and strobes
//   rdata                  captured read data
//   busy, done             busy in every non-IDLE state; 1-cycle done pulse
//
// Every output is registered from the next-state value. Strobes therefore
// change only on state transitions and never glitch.
// ---------------------------------------------------------------------------
module rtc_ad_sequencer #(
    parameter int GAP_CYC   = 2,
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rd_wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] addr_q,
    output logic [7:0] wdata_q,
    output logic       mux_sel,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    // The counter is loaded with (duration - 1). The state advances when the counter reads 0.
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYC - 1);
    localparam logic [3:0] PHASE_LOAD = 4'(PHASE_CYC - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       dir_reg, dir_next;          // 1 = read
    logic [7:0] addr_next, wdata_next, rdata_next;
    logic       launch_new;
    logic       in_a, in_d, d_strobe;

`ifdef RTC_CMD_QUEUE_EN
    logic       pend_valid_reg;
    logic       pend_dir_reg;
    logic [7:0] pend_addr_reg, pend_wdata_reg;
    logic       launch_pend;
    logic       pend_push;

    // Fill the slot only while a transaction is in flight and the slot is
    // empty. A start that arrives while the slot is full is dropped.
    assign pend_push = start && (state_reg != IDLE) && !pend_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_reg <= 1'b0;
            pend_dir_reg   <= 1'b0;
            pend_addr_reg  <= 8'h00;
            pend_wdata_reg <= 8'h00;
        end else if (launch_pend) begin
            pend_valid_reg <= 1'b0;
        end else if (pend_push) begin
            pend_valid_reg <= 1'b1;
            pend_dir_reg   <= rd_wr;
            pend_addr_reg  <= addr;
            pend_wdata_reg <= wdata;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        rdata_next = rdata;
        launch_new = 1'b0;
`ifdef RTC_CMD_QUEUE_EN
        launch_pend = 1'b0;
`endif
        cnt_next = (cnt_reg != 4'd0) ? cnt_reg - 4'd1 : cnt_reg;

        case (state_reg)
            IDLE: begin
`ifdef RTC_CMD_QUEUE_EN
                if (pend_valid_reg) launch_pend = 1'b1;
                else if (start)     launch_new  = 1'b1;
`else
                if (start) launch_new = 1'b1;
`endif
            end
            A_SETUP: if (cnt_reg == 4'd0) begin
                state_next = A_STROBE;
                cnt_next   = PHASE_LOAD;
            end
            A_STROBE: if (cnt_reg == 4'd0) begin
                state_next = A_HOLD;
                cnt_next   = GAP_LOAD;
            end
            A_HOLD: if (cnt_reg == 4'd0) begin
                state_next = D_SETUP;
                cnt_next   = GAP_LOAD;
            end
            D_SETUP: if (cnt_reg == 4'd0) begin
                state_next = D_STROBE;
                cnt_next   = PHASE_LOAD;
            end
            D_STROBE: if (cnt_reg == 4'd0) begin
                // Capture on the last strobe cycle, when the RTC data is settled.
                if (dir_reg) rdata_next = ad_in;
                state_next = D_HOLD;
                cnt_next   = GAP_LOAD;
            end
            D_HOLD: if (cnt_reg == 4'd0) begin
                state_next = DONE;
            end
            default: begin // DONE
                state_next = IDLE;
`ifdef RTC_CMD_QUEUE_EN
                if (pend_valid_reg) launch_pend = 1'b1;
`endif
            end
        endcase

        if (launch_new) begin
            state_next = A_SETUP;
            cnt_next   = GAP_LOAD;
            dir_next   = rd_wr;
            addr_next  = addr;
            wdata_next = wdata;
        end
`ifdef RTC_CMD_QUEUE_EN
        if (launch_pend) begin
            state_next = A_SETUP;
            cnt_next   = GAP_LOAD;
            dir_next   = pend_dir_reg;
            addr_next  = pend_addr_reg;
            wdata_next = pend_wdata_reg;
        end
`endif
    end

    // Output decode from the next state, so the registered outputs line up with the state register.
    always_comb begin
        in_a     = (state_next == A_SETUP) || (state_next == A_STROBE) ||
                   (state_next == A_HOLD);
        in_d     = (state_next == D_SETUP) || (state_next == D_STROBE) ||
                   (state_next == D_HOLD);
        d_strobe = (state_next == D_STROBE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            dir_reg   <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            rdata     <= 8'h00;
            mux_sel   <= 1'b1;
            ad_oe     <= 1'b0;
            cs_n      <= 1'b1;
            ad_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            addr_q    <= addr_next;
            wdata_q   <= wdata_next;
            rdata     <= rdata_next;
            mux_sel   <= in_a;
            ad_oe     <= in_a || (in_d && !dir_next);
            cs_n      <= !(in_a || in_d);
            ad_n      <= !(state_next == A_STROBE);
            rd_n      <= !(d_strobe && dir_next);
            wr_n      <= !(d_strobe && !dir_next);
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
        end
    end

endmodule
